// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB write-back, in-order commit.
// Detects a mispredicted branch as it retires and flushes the buffer behind it.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    // dispatcher allocation
    input  logic        alloc_signal_from_dispatcher,
    input  logic [4:0]  rd_from_dispatcher,
    input  logic        is_jump_from_dispatcher,
    input  logic        predicted_jump_from_dispatcher,
    output logic [4:0]  rob_id_to_dispatcher,
    output logic        rob_full,
    // operand queries
    input  logic [4:0]  Q1_from_dispatcher,
    input  logic [4:0]  Q2_from_dispatcher,
    output logic        Q1_ready,
    output logic        Q2_ready,
    output logic [31:0] V1_to_dispatcher,
    output logic [31:0] V2_to_dispatcher,
    // common data bus
    input  logic        alu_flag,
    input  logic [4:0]  alu_rob_id,
    input  logic [31:0] alu_result,
    input  logic        alu_jump_flag,
    input  logic [31:0] alu_target_pc,
    input  logic        lsb_flag,
    input  logic [4:0]  lsb_rob_id,
    input  logic [31:0] lsb_result,
    // commit and rollback
    output logic        output_commit_flag,
    output logic [4:0]  rd_to_reg,
    output logic [4:0]  Q_to_reg,
    output logic [31:0] V_to_reg,
    output logic        rollback_flag,
    output logic [31:0] target_pc_to_fetcher
);
    localparam int unsigned IDX_W = $clog2(ROB_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [4:0] ZERO_ROB = 5'd0;
    localparam logic [5:0] SIZE_ID = 6'(ROB_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

    logic [ROB_SIZE-1:0] busy_q, ready_q, is_jump_q, pred_q, actual_q;
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [31:0]         value_q  [ROB_SIZE];
    logic [31:0]         tpc_q    [ROB_SIZE];

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        commit_q, rollback_q;
    logic [4:0]  rd_reg_q, qid_reg_q;
    logic [31:0] val_reg_q, tpc_reg_q;

    logic             retire, flush, do_alloc, alu_wr, lsb_wr;
    logic [IDX_W-1:0] alu_idx, lsb_idx, q1_idx, q2_idx;

    function automatic logic [IDX_W-1:0] id2idx(input logic [4:0] id);
        return IDX_W'(id - 5'd1);
    endfunction

    function automatic logic id_ok(input logic [4:0] id);
        return (id != ZERO_ROB) && ({1'b0, id} <= SIZE_ID);
    endfunction

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // {ready, value} for one operand query, CDB bypass taking precedence over stored state
    function automatic logic [32:0] lookup(
        input logic [4:0]  q,
        input logic        ent_ready,
        input logic [31:0] ent_value,
        input logic        in_rst,
        input logic        en,
        input logic        a_flag,
        input logic [4:0]  a_id,
        input logic [31:0] a_val,
        input logic        l_flag,
        input logic [4:0]  l_id,
        input logic [31:0] l_val
    );
        logic [32:0] r;
        r = '0;
        if (!in_rst) begin
            if (q == ZERO_ROB)                   r = {1'b1, 32'd0};
            else if (en && a_flag && a_id == q)  r = {1'b1, a_val};
            else if (en && l_flag && l_id == q)  r = {1'b1, l_val};
            else if (id_ok(q) && ent_ready)      r = {1'b1, ent_value};
        end
        return r;
    endfunction

    assign rob_full             = (count_q == FULL_CNT);
    assign rob_id_to_dispatcher = 5'(tail_q) + 5'd1;

    always_comb begin
        alu_idx  = id2idx(alu_rob_id);
        lsb_idx  = id2idx(lsb_rob_id);
        retire   = rdy & busy_q[head_q] & ready_q[head_q];
        flush    = retire & is_jump_q[head_q] & (actual_q[head_q] != pred_q[head_q]);
        do_alloc = rdy & alloc_signal_from_dispatcher & ~rob_full & ~flush;
        alu_wr   = rdy & ~flush & alu_flag & id_ok(alu_rob_id) & busy_q[alu_idx];
        lsb_wr   = rdy & ~flush & lsb_flag & id_ok(lsb_rob_id) & busy_q[lsb_idx];

        head_d  = retire ? inc(head_q) : head_q;
        tail_d  = do_alloc ? inc(tail_q) : tail_q;
        count_d = count_q;
        if (do_alloc && !retire)      count_d = count_q + 1'b1;
        else if (!do_alloc && retire) count_d = count_q - 1'b1;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        q1_idx = id2idx(Q1_from_dispatcher);
        q2_idx = id2idx(Q2_from_dispatcher);
        {Q1_ready, V1_to_dispatcher} = lookup(Q1_from_dispatcher, ready_q[q1_idx],
            value_q[q1_idx], rst, rdy, alu_flag, alu_rob_id, alu_result,
            lsb_flag, lsb_rob_id, lsb_result);
        {Q2_ready, V2_to_dispatcher} = lookup(Q2_from_dispatcher, ready_q[q2_idx],
            value_q[q2_idx], rst, rdy, alu_flag, alu_rob_id, alu_result,
            lsb_flag, lsb_rob_id, lsb_result);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            commit_q   <= 1'b0;
            rollback_q <= 1'b0;
            rd_reg_q   <= '0;
            qid_reg_q  <= '0;
            val_reg_q  <= '0;
            tpc_reg_q  <= '0;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            commit_q   <= retire;
            rollback_q <= flush;
            if (retire) begin
                rd_reg_q  <= rd_q[head_q];
                qid_reg_q <= 5'(head_q) + 5'd1;
                val_reg_q <= value_q[head_q];
            end
            if (flush) begin
                tpc_reg_q <= tpc_q[head_q];
                busy_q    <= '0;
                ready_q   <= '0;
            end else begin
                if (retire) busy_q[head_q] <= 1'b0;
                if (do_alloc) begin
                    busy_q[tail_q]    <= 1'b1;
                    ready_q[tail_q]   <= 1'b0;
                    rd_q[tail_q]      <= rd_from_dispatcher;
                    is_jump_q[tail_q] <= is_jump_from_dispatcher;
                    pred_q[tail_q]    <= predicted_jump_from_dispatcher;
                    actual_q[tail_q]  <= 1'b0;
                end
                if (alu_wr) begin
                    ready_q[alu_idx]  <= 1'b1;
                    value_q[alu_idx]  <= alu_result;
                    actual_q[alu_idx] <= alu_jump_flag;
                    tpc_q[alu_idx]    <= alu_target_pc;
                end
                if (lsb_wr) begin
                    ready_q[lsb_idx] <= 1'b1;
                    value_q[lsb_idx] <= lsb_result;
                end
            end
        end
    end

    // Pulses freeze with the rest of the state while stalled but are never shown then.
    assign output_commit_flag   = commit_q & rdy & ~rst;
    assign rollback_flag        = rollback_q & rdy & ~rst;
    assign rd_to_reg            = rd_reg_q;
    assign Q_to_reg             = qid_reg_q;
    assign V_to_reg             = val_reg_q;
    assign target_pc_to_fetcher = tpc_reg_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_reorder_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy;
    logic        alloc_signal_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic        is_jump_from_dispatcher, predicted_jump_from_dispatcher;
    logic [4:0]  rob_id_to_dispatcher;
    logic        rob_full;
    logic [4:0]  Q1_from_dispatcher, Q2_from_dispatcher;
    logic        Q1_ready, Q2_ready;
    logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
    logic        alu_flag;
    logic [4:0]  alu_rob_id;
    logic [31:0] alu_result;
    logic        alu_jump_flag;
    logic [31:0] alu_target_pc;
    logic        lsb_flag;
    logic [4:0]  lsb_rob_id;
    logic [31:0] lsb_result;
    logic        output_commit_flag;
    logic [4:0]  rd_to_reg, Q_to_reg;
    logic [31:0] V_to_reg;
    logic        rollback_flag;
    logic [31:0] target_pc_to_fetcher;

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .rdy                            (rdy),
        .alloc_signal_from_dispatcher   (alloc_signal_from_dispatcher),
        .rd_from_dispatcher             (rd_from_dispatcher),
        .is_jump_from_dispatcher        (is_jump_from_dispatcher),
        .predicted_jump_from_dispatcher (predicted_jump_from_dispatcher),
        .rob_id_to_dispatcher           (rob_id_to_dispatcher),
        .rob_full                       (rob_full),
        .Q1_from_dispatcher             (Q1_from_dispatcher),
        .Q2_from_dispatcher             (Q2_from_dispatcher),
        .Q1_ready                       (Q1_ready),
        .Q2_ready                       (Q2_ready),
        .V1_to_dispatcher               (V1_to_dispatcher),
        .V2_to_dispatcher               (V2_to_dispatcher),
        .alu_flag                       (alu_flag),
        .alu_rob_id                     (alu_rob_id),
        .alu_result                     (alu_result),
        .alu_jump_flag                  (alu_jump_flag),
        .alu_target_pc                  (alu_target_pc),
        .lsb_flag                       (lsb_flag),
        .lsb_rob_id                     (lsb_rob_id),
        .lsb_result                     (lsb_result),
        .output_commit_flag             (output_commit_flag),
        .rd_to_reg                      (rd_to_reg),
        .Q_to_reg                       (Q_to_reg),
        .V_to_reg                       (V_to_reg),
        .rollback_flag                  (rollback_flag),
        .target_pc_to_fetcher           (target_pc_to_fetcher)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: program-order queue of live ids plus per-id attributes.
    int          rob_q[$];
    int          next_id = 1;
    logic        m_ready [32];
    logic [4:0]  m_rd    [32];
    logic [31:0] m_val   [32];
    logic        m_isj   [32];
    logic        m_pred  [32];
    logic        m_act   [32];
    logic [31:0] m_tpc   [32];
    logic        e_commit = 1'b0, e_rb = 1'b0;
    logic [4:0]  e_rd = '0, e_qid = '0;
    logic [31:0] e_v = '0, e_tpc = '0;

    function automatic bit in_rob(input int id);
        foreach (rob_q[i]) if (rob_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update();
        bit alu_ok, lsb_ok, was_full, flushed;
        int h;
        if (rst) begin
            rob_q.delete();
            next_id = 1;
            for (int i = 0; i < 32; i++) m_ready[i] = 1'b0;
            e_commit = 1'b0; e_rb = 1'b0;
            e_rd = '0; e_qid = '0; e_v = '0; e_tpc = '0;
            return;
        end
        if (!rdy) return;
        alu_ok   = alu_flag && in_rob(int'(alu_rob_id));
        lsb_ok   = lsb_flag && in_rob(int'(lsb_rob_id));
        was_full = (rob_q.size() == 16);
        flushed  = 1'b0;
        e_commit = 1'b0;
        e_rb     = 1'b0;
        if (rob_q.size() > 0 && m_ready[rob_q[0]]) begin
            h = rob_q[0];
            e_commit = 1'b1;
            e_rd = m_rd[h]; e_qid = 5'(h); e_v = m_val[h];
            if (m_isj[h] && (m_act[h] != m_pred[h])) begin
                e_rb = 1'b1; e_tpc = m_tpc[h];
                flushed = 1'b1;
                rob_q.delete();
                next_id = 1;
                for (int i = 0; i < 32; i++) m_ready[i] = 1'b0;
            end else begin
                void'(rob_q.pop_front());
            end
        end
        if (!flushed) begin
            if (alu_ok) begin
                m_ready[alu_rob_id] = 1'b1; m_val[alu_rob_id] = alu_result;
                m_act[alu_rob_id] = alu_jump_flag; m_tpc[alu_rob_id] = alu_target_pc;
            end
            if (lsb_ok) begin
                m_ready[lsb_rob_id] = 1'b1; m_val[lsb_rob_id] = lsb_result;
            end
            if (alloc_signal_from_dispatcher && !was_full) begin
                rob_q.push_back(next_id);
                m_ready[next_id] = 1'b0; m_rd[next_id] = rd_from_dispatcher;
                m_isj[next_id] = is_jump_from_dispatcher;
                m_pred[next_id] = predicted_jump_from_dispatcher;
                m_act[next_id] = 1'b0;
                next_id = (next_id == 16) ? 1 : next_id + 1;
            end
        end
    endtask

    task automatic exp_query(input logic [4:0] q, output logic r, output logic [31:0] v);
        r = 1'b0; v = '0;
        if (rst) return;
        if (q == 5'd0) r = 1'b1;
        else if (rdy && alu_flag && alu_rob_id == q) begin r = 1'b1; v = alu_result; end
        else if (rdy && lsb_flag && lsb_rob_id == q) begin r = 1'b1; v = lsb_result; end
        else if (q <= 5'd16 && m_ready[q]) begin r = 1'b1; v = m_val[q]; end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1;
        alloc_signal_from_dispatcher = 1'b0; rd_from_dispatcher = '0;
        is_jump_from_dispatcher = 1'b0; predicted_jump_from_dispatcher = 1'b0;
        Q1_from_dispatcher = '0; Q2_from_dispatcher = '0;
        alu_flag = 1'b0; alu_rob_id = '0; alu_result = '0;
        alu_jump_flag = 1'b0; alu_target_pc = '0;
        lsb_flag = 1'b0; lsb_rob_id = '0; lsb_result = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (rob_id_to_dispatcher !== 5'd1 || rob_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ptr: rob_id=%0d full=%b, want 1/0", rob_id_to_dispatcher, rob_full);
        end
        n_cmp++;
        if (output_commit_flag !== 1'b0 || rollback_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: commit=%b rollback=%b, want 0/0",
                     output_commit_flag, rollback_flag);
        end
        n_cmp++;
        if (Q1_ready !== 1'b0 || Q2_ready !== 1'b0 || V1_to_dispatcher !== 32'd0) begin
            n_err++;
            $display("FAIL reset_query: q1r=%b q2r=%b v1=%h, want 0/0/0",
                     Q1_ready, Q2_ready, V1_to_dispatcher);
        end
        n_cmp++;
        if (rd_to_reg !== 5'd0 || Q_to_reg !== 5'd0 || V_to_reg !== 32'd0 ||
            target_pc_to_fetcher !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: rd=%0d q=%0d v=%h tpc=%h, want all 0",
                     rd_to_reg, Q_to_reg, V_to_reg, target_pc_to_fetcher);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic_commit();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd5;
        #1;
        n_cmp++;
        if (rob_id_to_dispatcher !== 5'd1) begin
            n_err++; $display("FAIL basic_id: got %0d want 1", rob_id_to_dispatcher);
        end
        tick();
        idle();
        alu_flag = 1'b1; alu_rob_id = 5'd1; alu_result = 32'h2A;
        tick();
        idle();
        #1;
        n_cmp++;
        if (output_commit_flag !== 1'b0) begin
            n_err++; $display("FAIL basic_early: commit=%b want 0", output_commit_flag);
        end
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b1 || rd_to_reg !== 5'd5 || Q_to_reg !== 5'd1 ||
            V_to_reg !== 32'h2A) begin
            n_err++;
            $display("FAIL basic_commit: f=%b rd=%0d q=%0d v=%h, want 1/5/1/2a",
                     output_commit_flag, rd_to_reg, Q_to_reg, V_to_reg);
        end
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b0) begin
            n_err++; $display("FAIL basic_single: commit=%b want 0", output_commit_flag);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd0;
        tick();
        idle();
        lsb_flag = 1'b1; lsb_rob_id = 5'd1; lsb_result = 32'hBEEF;
        tick();
        idle();
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b1 || rd_to_reg !== 5'd0 || V_to_reg !== 32'hBEEF) begin
            n_err++;
            $display("FAIL rd_zero: f=%b rd=%0d v=%h, want 1/0/beef",
                     output_commit_flag, rd_to_reg, V_to_reg);
        end
    endtask

    task automatic test_full();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_from_dispatcher = 5'(i + 1);
            tick();
        end
        n_cmp++;
        if (rob_full !== 1'b1 || rob_id_to_dispatcher !== 5'd1) begin
            n_err++;
            $display("FAIL full_set: full=%b id=%0d, want 1/1", rob_full, rob_id_to_dispatcher);
        end
        tick();
        n_cmp++;
        if (rob_full !== 1'b1 || rob_id_to_dispatcher !== 5'd1) begin
            n_err++;
            $display("FAIL full_ignore: full=%b id=%0d, want 1/1", rob_full, rob_id_to_dispatcher);
        end
        idle();
        Q1_from_dispatcher = 5'd16;
        #1;
        n_cmp++;
        if (Q1_ready !== 1'b0 || V1_to_dispatcher !== 32'd0) begin
            n_err++;
            $display("FAIL full_query: r=%b v=%h, want 0/0", Q1_ready, V1_to_dispatcher);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd1;
        tick();
        rd_from_dispatcher = 5'd2;
        tick();
        idle();
        lsb_flag = 1'b1; lsb_rob_id = 5'd2; lsb_result = 32'h22;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (output_commit_flag !== 1'b0) begin
                n_err++; $display("FAIL ooo_wait%0d: commit=%b want 0", i, output_commit_flag);
            end
        end
        alu_flag = 1'b1; alu_rob_id = 5'd1; alu_result = 32'h11;
        tick();
        idle();
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b1 || Q_to_reg !== 5'd1 || V_to_reg !== 32'h11) begin
            n_err++;
            $display("FAIL ooo_first: f=%b q=%0d v=%h, want 1/1/11",
                     output_commit_flag, Q_to_reg, V_to_reg);
        end
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b1 || Q_to_reg !== 5'd2 || V_to_reg !== 32'h22 ||
            rd_to_reg !== 5'd2) begin
            n_err++;
            $display("FAIL ooo_second: f=%b q=%0d rd=%0d v=%h, want 1/2/2/22",
                     output_commit_flag, Q_to_reg, rd_to_reg, V_to_reg);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd3;
        is_jump_from_dispatcher = 1'b1; predicted_jump_from_dispatcher = 1'b0;
        tick();
        is_jump_from_dispatcher = 1'b0; rd_from_dispatcher = 5'd4;
        alu_flag = 1'b1; alu_rob_id = 5'd1; alu_result = 32'h44;
        alu_jump_flag = 1'b1; alu_target_pc = 32'h100;
        tick();
        idle();
        // Allocation in the flush cycle must be discarded.
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd9;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rollback_flag !== 1'b1 || target_pc_to_fetcher !== 32'h100) begin
            n_err++;
            $display("FAIL mp_rollback: rb=%b tpc=%h, want 1/100",
                     rollback_flag, target_pc_to_fetcher);
        end
        n_cmp++;
        if (output_commit_flag !== 1'b1 || Q_to_reg !== 5'd1 || rd_to_reg !== 5'd3) begin
            n_err++;
            $display("FAIL mp_commit: f=%b q=%0d rd=%0d, want 1/1/3",
                     output_commit_flag, Q_to_reg, rd_to_reg);
        end
        n_cmp++;
        if (rob_full !== 1'b0 || rob_id_to_dispatcher !== 5'd1) begin
            n_err++;
            $display("FAIL mp_empty: full=%b id=%0d, want 0/1", rob_full, rob_id_to_dispatcher);
        end
        tick();
        n_cmp++;
        if (rollback_flag !== 1'b0 || output_commit_flag !== 1'b0) begin
            n_err++;
            $display("FAIL mp_pulse: rb=%b commit=%b, want 0/0", rollback_flag, output_commit_flag);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        idle();
        Q1_from_dispatcher = 5'd3; Q2_from_dispatcher = 5'd2;
        alu_flag = 1'b1; alu_rob_id = 5'd3; alu_result = 32'd7;
        #1;
        n_cmp++;
        if (Q1_ready !== 1'b1 || V1_to_dispatcher !== 32'd7) begin
            n_err++;
            $display("FAIL bypass_hit: r=%b v=%h, want 1/7", Q1_ready, V1_to_dispatcher);
        end
        n_cmp++;
        if (Q2_ready !== 1'b0 || V2_to_dispatcher !== 32'd0) begin
            n_err++;
            $display("FAIL bypass_miss: r=%b v=%h, want 0/0", Q2_ready, V2_to_dispatcher);
        end
        tick();
        idle();
        Q2_from_dispatcher = 5'd3;
        #1;
        n_cmp++;
        if (Q2_ready !== 1'b1 || V2_to_dispatcher !== 32'd7) begin
            n_err++;
            $display("FAIL bypass_stored: r=%b v=%h, want 1/7", Q2_ready, V2_to_dispatcher);
        end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        alloc_signal_from_dispatcher = 1'b1; rd_from_dispatcher = 5'd6;
        tick();
        idle();
        alu_flag = 1'b1; alu_rob_id = 5'd1; alu_result = 32'h55;
        tick();
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (output_commit_flag !== 1'b0 || rollback_flag !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: commit=%b rb=%b, want 0/0",
                         i, output_commit_flag, rollback_flag);
            end
        end
        rdy = 1'b1;
        tick();
        n_cmp++;
        if (output_commit_flag !== 1'b1 || V_to_reg !== 32'h55 || rd_to_reg !== 5'd6) begin
            n_err++;
            $display("FAIL stall_release: f=%b rd=%0d v=%h, want 1/6/55",
                     output_commit_flag, rd_to_reg, V_to_reg);
        end
    endtask

    task automatic test_random();
        int cand[$];
        int k;
        logic r1, r2;
        logic [31:0] v1, v2;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            alloc_signal_from_dispatcher = $urandom_range(0, 1);
            rd_from_dispatcher = 5'($urandom_range(0, 31));
            is_jump_from_dispatcher = ($urandom_range(0, 7) == 0);
            predicted_jump_from_dispatcher = $urandom_range(0, 1);
            cand.delete();
            foreach (rob_q[i]) if (!m_ready[rob_q[i]]) cand.push_back(rob_q[i]);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                alu_flag = 1'b1; alu_rob_id = 5'(cand[k]); cand.delete(k);
                alu_result = $urandom; alu_jump_flag = $urandom_range(0, 1);
                alu_target_pc = $urandom;
            end
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                lsb_flag = 1'b1; lsb_rob_id = 5'(cand[k]); lsb_result = $urandom;
            end
            Q1_from_dispatcher = 5'($urandom_range(0, 16));
            Q2_from_dispatcher = 5'($urandom_range(0, 16));
            #1;
            exp_query(Q1_from_dispatcher, r1, v1);
            exp_query(Q2_from_dispatcher, r2, v2);
            n_cmp++;
            if (Q1_ready !== r1 || V1_to_dispatcher !== v1) begin
                n_err++;
                $display("FAIL rnd_q1 cyc%0d: got %b/%h want %b/%h",
                         cyc, Q1_ready, V1_to_dispatcher, r1, v1);
            end
            n_cmp++;
            if (Q2_ready !== r2 || V2_to_dispatcher !== v2) begin
                n_err++;
                $display("FAIL rnd_q2 cyc%0d: got %b/%h want %b/%h",
                         cyc, Q2_ready, V2_to_dispatcher, r2, v2);
            end
            n_cmp++;
            if (output_commit_flag !== (e_commit & rdy & ~rst) ||
                rollback_flag !== (e_rb & rdy & ~rst)) begin
                n_err++;
                $display("FAIL rnd_flags cyc%0d: commit=%b rb=%b want %b/%b", cyc,
                         output_commit_flag, rollback_flag, e_commit & rdy & ~rst,
                         e_rb & rdy & ~rst);
            end
            if (!rst) begin
                n_cmp++;
                if (rob_full !== (rob_q.size() == 16) || rob_id_to_dispatcher !== 5'(next_id)) begin
                    n_err++;
                    $display("FAIL rnd_alloc cyc%0d: full=%b id=%0d want %b/%0d", cyc,
                             rob_full, rob_id_to_dispatcher, rob_q.size() == 16, next_id);
                end
            end
            if (e_commit && rdy && !rst) begin
                n_cmp++;
                if (rd_to_reg !== e_rd || Q_to_reg !== e_qid || V_to_reg !== e_v) begin
                    n_err++;
                    $display("FAIL rnd_commit cyc%0d: rd=%0d q=%0d v=%h want %0d/%0d/%h", cyc,
                             rd_to_reg, Q_to_reg, V_to_reg, e_rd, e_qid, e_v);
                end
            end
            if (e_rb && rdy && !rst) begin
                n_cmp++;
                if (target_pc_to_fetcher !== e_tpc) begin
                    n_err++;
                    $display("FAIL rnd_tpc cyc%0d: got %h want %h", cyc, target_pc_to_fetcher, e_tpc);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_commit();
        test_rd_zero();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_bypass();
        test_rdy_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of entries; ROB id = slot index + 1, width 5 bits; id 0 (`ZERO_ROB`) means "no producer".
REQ-002 SHALL have one clock, clk; reset is synchronous and active-high: rst; rdy is a global clock-enable.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  high = advance state; low = freeze all state.
REQ-006 alloc_signal_from_dispatcher  in  1  allocate the tail entry this cycle.
REQ-007 rd_from_dispatcher  in  5  destination register of the allocated instruction.
REQ-008 is_jump_from_dispatcher / predicted_jump_from_dispatcher  in  1/1  branch flag and predicted-taken flag.
REQ-009 rob_id_to_dispatcher  out  5  id the next allocation receives (tail index + 1).
REQ-010 rob_full  out  1  count == ROB_SIZE.
REQ-011 Q1_from_dispatcher / Q2_from_dispatcher  in  5/5  operand producer ids to query.
REQ-012 Q1_ready / Q2_ready  out  1/1  the queried entry's value is available.
REQ-013 V1_to_dispatcher / V2_to_dispatcher  out  32/32  available value of the queried entry.
REQ-014 alu_flag, alu_rob_id, alu_result, alu_jump_flag, alu_target_pc  in  1/5/32/1/32  ALU write-back on the CDB.
REQ-015 lsb_flag, lsb_rob_id, lsb_result  in  1/5/32  load/store write-back on the CDB.
REQ-016 output_commit_flag  out  1  commit valid, sent to the register file.
REQ-017 rd_to_reg / Q_to_reg / V_to_reg  out  5/5/32  committed rd, committing ROB id, committed value.
REQ-018 rollback_flag  out  1  misprediction flush pulse.
REQ-019 target_pc_to_fetcher  out  32  correct PC, valid while rollback_flag is high.

Function
REQ-020 SHALL implement a circular buffer with head, tail and count; both pointers wrap from ROB_SIZE-1 to 0.
REQ-021 SHALL give each entry busy, ready, rd, value, is_jump, predicted_jump, actual_jump and target_pc fields.
REQ-022 On alloc with rdy high and rob_full low, SHALL write the tail entry (busy=1, ready=0) and advance tail.
REQ-023 An alloc while rob_full is high SHALL be ignored.
REQ-024 On a CDB flag, SHALL write result, actual_jump and target_pc into entry (id-1) and set ready=1, but only if that entry is busy.
REQ-025 ALU and LSB write-backs in the same cycle SHALL both apply (distinct ids).
REQ-026 Qn_ready SHALL be 1 when Qn==0; or when the entry is ready; or when alu_flag/lsb_flag carries that id in the same cycle (combinational bypass, CDB value forwarded).
REQ-027 Otherwise, Qn_ready SHALL be 0 and Vn SHALL be 0.
REQ-028 Each cycle, if the head entry is busy and ready, SHALL retire it: clear busy, advance head, decrement count.
REQ-029 At the next edge after retirement, SHALL register output_commit_flag=1 with rd_to_reg=rd, Q_to_reg=head+1 and V_to_reg=value; latency is one cycle from head ready to commit visible.
REQ-030 SHALL retire at most one entry per cycle; output_commit_flag SHALL be 0 in cycles with no retirement.
REQ-031 rd==0 entries SHALL still commit with output_commit_flag=1 and rd_to_reg=0.
REQ-032 If a retiring entry has is_jump=1 and actual_jump != predicted_jump, SHALL register rollback_flag=1 for exactly one cycle, with target_pc_to_fetcher=entry target_pc.
REQ-033 In the same misprediction case, SHALL commit the jump itself (commit_flag=1), then clear every busy bit and set head=tail=count=0.
REQ-034 A flush SHALL take priority over any same-cycle alloc or write-back; those are discarded.
REQ-035 Simultaneous alloc and retirement SHALL leave count unchanged.
REQ-036 rob_full SHALL reflect the registered count only; no same-cycle credit is given for a retirement.
REQ-037 With rdy low, SHALL hold all state, drive output_commit_flag=0 and rollback_flag=0, and ignore all inputs.

Reset
REQ-038 With rst high at a clock edge, SHALL clear all busy/ready bits and set head=tail=count=0.
REQ-039 During and after reset, rob_id_to_dispatcher SHALL be 1, and every other output (rob_full, commit/rollback flags, data outputs, Q1_ready/Q2_ready) SHALL be 0.
REQ-040 rst SHALL override rdy and an in-progress rollback.

Verification
REQ-041 Alloc rd=5 (id 1); ALU writes id1=0x2A -> next cycle commit_flag=1, rd_to_reg=5, Q_to_reg=1, V_to_reg=0x2A.
REQ-042 Alloc 16 entries with no write-back -> rob_full=1; a 17th alloc is ignored; tail wraps and rob_id_to_dispatcher=1.
REQ-043 Write back id2 before id1 -> no commit until id1 is written; then commits id1 and id2 in consecutive cycles.
REQ-044 Branch predicted not-taken, ALU reports taken with target 0x100 -> rollback_flag=1 for one cycle, target_pc_to_fetcher=0x100, rob_full=0, next alloc gets id 1.
REQ-045 Query Q1=3 while alu_flag writes id3=7 in the same cycle -> Q1_ready=1, V1_to_dispatcher=7.
REQ-046 Hold rdy=0 for 3 cycles with head ready -> no commit during the hold; commit occurs after rdy returns high.
